lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/core_pkg.sv | 18 +
 rtl/lsu_align.sv | 32 +++
 rtl/lsu.sv | 87 ++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared control-word indices, funct3 encodings, opcodes and LSU state
package core_pkg;
  localparam int unsigned CTRL_MEM_TO_REG = 0;
  localparam int unsigned CTRL_REG_WE     = 1;
  localparam int unsigned CTRL_MEM_WE     = 2;
  localparam int unsigned CTRL_MEM_RE     = 3;
  localparam int unsigned CTRL_IS_BRANCH  = 4;
  localparam int unsigned CTRL_ALUSRC     = 5;
  localparam int unsigned CTRL_ALUOP_LO   = 6;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} lsu_state_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store lane replication, load extraction and access legality
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_data
);
  logic [31:0] sh;
  logic size_ok, f3_ok;
  assign sh = rdata >> {lane, 3'b000};
  assign size_ok = funct3[1:0] == 2'b00 || (funct3[1:0] == 2'b01 && !lane[0]) ||
                   (funct3[1:0] == 2'b10 && lane == 2'b00);
  assign f3_ok = is_store ? funct3 inside {F3_B, F3_H, F3_W}
                          : funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign legal = size_ok && f3_ok;
  assign be = funct3[1:0] == 2'b00 ? 4'b0001 << lane :
              funct3[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) :
              funct3[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
  assign wdata_rep = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                     funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
  assign ld_data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                   funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                   funct3 == F3_BU ? {24'd0, sh[7:0]} :
                   funct3 == F3_HU ? {16'd0, sh[15:0]} : rdata;
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit bridging the pipeline to a req/ready, rvalid bus
module lsu
  import core_pkg::*;
#(
  parameter int CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic                  valid_i,
  input  logic [2:0]            funct3_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  stall_o,
  output logic                  req_o,
  output logic                  we_o,
  output logic [31:0]           addr_o,
  output logic [31:0]           wdata_o,
  output logic [3:0]            be_o,
  input  logic                  ready_i,
  input  logic                  rvalid_i,
  input  logic [31:0]           rdata_i,
  output logic                  ld_valid_o,
  output logic [31:0]           ld_data_o,
  output logic                  st_done_o,
  output logic                  err_o
);
  lsu_state_e state, state_nx;
  logic mem_re, mem_we, is_idle, legal, launch, bad;
  logic [31:0] addr_q, wdata_rep, ld_data;
  logic [2:0] f3_q;
  logic [3:0] be;
  logic ctrl_unused;
  assign ctrl_unused = ^{ctrl_i[CTRL_WIDTH-1:4], ctrl_i[1:0]};
  assign mem_re = ctrl_i[CTRL_MEM_RE];
  assign mem_we = ctrl_i[CTRL_MEM_WE];
  assign is_idle = state == S_IDLE;
  // The aligner sees the live instruction while idle and the latched one afterwards
  lsu_align u_align (
    .funct3   (is_idle ? funct3_i : f3_q),
    .lane     (is_idle ? addr_i[1:0] : addr_q[1:0]),
    .is_store (mem_we),
    .wdata    (wdata_i),
    .rdata    (rdata_i),
    .legal    (legal),
    .be       (be),
    .wdata_rep(wdata_rep),
    .ld_data  (ld_data)
  );
  assign launch = is_idle && valid_i && (mem_re ^ mem_we) && legal;
  assign bad = is_idle && valid_i && ((mem_re && mem_we) || ((mem_re ^ mem_we) && !legal));
  assign req_o = state == S_REQ;
  assign addr_o = {addr_q[31:2], 2'b00};
  always_comb begin
    state_nx = launch ? S_REQ :
               (state == S_REQ && ready_i) ? (we_o ? S_IDLE : S_RSP) :
               (state == S_RSP && rvalid_i) ? S_IDLE : state;
    stall_o = launch || (state == S_REQ && !(we_o && ready_i)) || (state == S_RSP && !rvalid_i);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      f3_q       <= '0;
      we_o       <= 1'b0;
      be_o       <= '0;
      wdata_o    <= '0;
      ld_valid_o <= 1'b0;
      ld_data_o  <= '0;
      st_done_o  <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) begin
        addr_q  <= addr_i;
        f3_q    <= funct3_i;
        we_o    <= mem_we;
        be_o    <= be;
        wdata_o <= wdata_rep;
      end
      ld_valid_o <= state == S_RSP && rvalid_i;
      if (state == S_RSP && rvalid_i) ld_data_o <= ld_data;
      st_done_o <= state == S_REQ && ready_i && we_o;
      err_o     <= bad;
    end
  end
endmodule
